// File: rtl/truth_table_scanner_if.sv
// Signal bundle between the truth-table scanner and its board/bench side.
//   start_pin, step_pin : raw (upstream-debounced) buttons
//   mode_pin            : 0 = auto dwell, 1 = single-step
//   dut_out             : response of the circuit under test
//   dut_in              : vector applied to the circuit under test
//   table_out           : captured table, bit k = response to vector k
//   busy, done          : scan status
// The slave modport is the scanner; master is whatever drives the buttons.
interface truth_table_scanner_if #(
    parameter int N_IN = 3
);
    logic                 start_pin;
    logic                 step_pin;
    logic                 mode_pin;
    logic                 dut_out;
    logic [N_IN-1:0]      dut_in;
    logic [2**N_IN-1:0]   table_out;
    logic                 busy;
    logic                 done;

    modport master (
        output start_pin, step_pin, mode_pin, dut_out,
        input  dut_in, table_out, busy, done
    );

    modport slave (
        input  start_pin, step_pin, mode_pin, dut_out,
        output dut_in, table_out, busy, done
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks the inputs of a small combinational circuit
// through all 2**N_IN vectors in ascending order, holds each for
// SETTLE_CYCLES, samples the single output into table_out, then either
// dwells DWELL_CYCLES (auto) or waits for a step button (step mode).
// Ports:
//   clk_pin : system clock
//   rst_pin : asynchronous active-high reset, clears everything
//   io      : scanner side of truth_table_scanner_if (buttons, mode
//             switch, circuit output in; vector, table, busy, done out)
module truth_table_scanner #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int DWELL_CYCLES  = 100000000
) (
    input  logic                  clk_pin,
    input  logic                  rst_pin,
    truth_table_scanner_if.slave  io
);
    localparam int TBL_W   = 2**N_IN;
    localparam int CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [N_IN-1:0]  VEC_LAST    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_CAPTURE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [TBL_W-1:0]   table_q, table_d;
    logic               mode_q, mode_d;

    // Two synchronizer stages plus one delay stage per button.
    logic start_s1_q, start_s1_d, start_s2_q, start_s2_d, start_s3_q, start_s3_d;
    logic step_s1_q, step_s1_d, step_s2_q, step_s2_d, step_s3_q, step_s3_d;
    logic start_pulse, step_pulse;

    assign start_pulse = start_s2_q & ~start_s3_q;
    assign step_pulse  = step_s2_q & ~step_s3_q;

    // State register
    always_ff @(posedge clk_pin or posedge rst_pin) begin
        if (rst_pin) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            vec_q      <= '0;
            table_q    <= '0;
            mode_q     <= 1'b0;
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            start_s3_q <= 1'b0;
            step_s1_q  <= 1'b0;
            step_s2_q  <= 1'b0;
            step_s3_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vec_q      <= vec_d;
            table_q    <= table_d;
            mode_q     <= mode_d;
            start_s1_q <= start_s1_d;
            start_s2_q <= start_s2_d;
            start_s3_q <= start_s3_d;
            step_s1_q  <= step_s1_d;
            step_s2_q  <= step_s2_d;
            step_s3_q  <= step_s3_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        vec_d      = vec_q;
        table_d    = table_q;
        mode_d     = mode_q;
        start_s1_d = io.start_pin;
        start_s2_d = start_s1_q;
        start_s3_d = start_s2_q;
        step_s1_d  = io.step_pin;
        step_s2_d  = step_s1_q;
        step_s3_d  = step_s2_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_pulse) begin
                    mode_d  = io.mode_pin;
                    table_d = '0;
                    vec_d   = '0;
                    cnt_d   = '0;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                table_d[vec_q] = io.dut_out;
                cnt_d          = '0;
                state_d        = (vec_q == VEC_LAST) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                // Step mode ignores the dwell counter entirely; auto mode
                // ignores step pulses, so neither can leak into the other.
                if (mode_q) begin
                    if (step_pulse) begin
                        vec_d   = vec_q + N_IN'(1);
                        state_d = S_APPLY;
                    end
                end else if (cnt_q == DWELL_LAST) begin
                    cnt_d   = '0;
                    vec_d   = vec_q + N_IN'(1);
                    state_d = S_APPLY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        io.dut_in    = vec_q;
        io.table_out = table_q;
        io.busy      = (state_q == S_APPLY) || (state_q == S_CAPTURE) || (state_q == S_WAIT);
        io.done      = (state_q == S_DONE);
    end
endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed-plus-random bench for truth_table_scanner with N_IN=3,
// SETTLE_CYCLES=2, DWELL_CYCLES=3. The circuit under test is a lookup
// into an 8-bit function table fn; expected scan timing and contents are
// computed from the scan rules with plain arithmetic.
module tb_truth_table_scanner;
    localparam int N_IN   = 3;
    localparam int SETTLE = 2;
    localparam int DWELL  = 3;
    localparam int PER_VEC = SETTLE + 1 + DWELL;                 // 6
    localparam int SCAN_LEN = 8 * (SETTLE + 1) + 7 * DWELL;      // 45

    logic       clk_pin;
    logic       rst_pin;
    logic [7:0] fn;
    int         checks;
    int         failures;

    truth_table_scanner_if #(.N_IN(N_IN)) ifc ();

    truth_table_scanner #(
        .N_IN          (N_IN),
        .SETTLE_CYCLES (SETTLE),
        .DWELL_CYCLES  (DWELL)
    ) dut (
        .clk_pin (clk_pin),
        .rst_pin (rst_pin),
        .io      (ifc.slave)
    );

    assign ifc.dut_out = fn[ifc.dut_in];

    initial clk_pin = 1'b0;
    always #5 clk_pin = ~clk_pin;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_dut_in"}, 32'(ifc.dut_in), 32'd0);
        check({tag, "_table"}, 32'(ifc.table_out), 32'd0);
        check({tag, "_busy"}, 32'(ifc.busy), 32'd0);
        check({tag, "_done"}, 32'(ifc.done), 32'd0);
    endtask

    // Bits of the table already captured t cycles after the first APPLY.
    function automatic logic [7:0] captured(input logic [7:0] f, input int t);
        int n;
        n = (t >= SETTLE + 1) ? ((t - SETTLE - 1) / PER_VEC + 1) : 0;
        if (n > 8) n = 8;
        return f & 8'((32'd1 << n) - 1);
    endfunction

    // One auto scan. Cycle k counts posedges from the one that first
    // samples start_pin high; the first APPLY cycle follows posedge 3.
    task automatic run_auto(input logic [7:0] f, input bit inject, input int abort_k, input string tag);
        int t;
        fn = f;
        @(negedge clk_pin);
        ifc.mode_pin  = 1'b0;
        ifc.start_pin = 1'b1;
        for (int k = 1; k <= SCAN_LEN + 3; k++) begin
            @(negedge clk_pin);
            t = k - 3;
            if (k == 2) check({tag, "_not_yet"}, 32'(ifc.busy), 32'd0);
            if (k == 3) ifc.start_pin = 1'b0;
            if (inject) begin
                if (k == 10) ifc.start_pin = 1'b1;
                if (k == 12) ifc.start_pin = 1'b0;
                if (k == 15) ifc.step_pin = 1'b1;
                if (k == 17) ifc.step_pin = 1'b0;
                if (k == 20) ifc.mode_pin = 1'b1;
                if (k == 33) ifc.step_pin = 1'b1;
                if (k == 34) ifc.step_pin = 1'b0;
            end
            if (k == abort_k) begin
                #2 rst_pin = 1'b1;
                #1 check_idle_outputs({tag, "_async_rst"});
                @(negedge clk_pin);
                rst_pin      = 1'b0;
                ifc.mode_pin = 1'b0;
                return;
            end
            if (t >= 0 && t < SCAN_LEN) begin
                check({tag, "_vec"}, 32'(ifc.dut_in), 32'(t / PER_VEC));
                check({tag, "_busy"}, 32'(ifc.busy), 32'd1);
                check({tag, "_done"}, 32'(ifc.done), 32'd0);
                check({tag, "_partial"}, 32'(ifc.table_out), 32'(captured(f, t)));
            end
            if (t == SCAN_LEN) begin
                check({tag, "_end_done"}, 32'(ifc.done), 32'd1);
                check({tag, "_end_busy"}, 32'(ifc.busy), 32'd0);
                check({tag, "_end_table"}, 32'(ifc.table_out), 32'(f));
                check({tag, "_end_vec"}, 32'(ifc.dut_in), 32'd7);
            end
        end
        ifc.mode_pin = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge clk_pin);
        ifc.step_pin = 1'b1;
        repeat (2) @(negedge clk_pin);
        ifc.step_pin = 1'b0;
        repeat (10) @(negedge clk_pin);
    endtask

    initial begin
        logic [7:0] r;
        checks        = 0;
        failures      = 0;
        fn            = 8'h00;
        rst_pin       = 1'b1;
        ifc.start_pin = 1'b0;
        ifc.step_pin  = 1'b0;
        ifc.mode_pin  = 1'b0;

        // Reset, then idle with no start edge
        repeat (2) @(negedge clk_pin);
        check_idle_outputs("in_reset");
        rst_pin = 1'b0;
        repeat (20) @(negedge clk_pin);
        check_idle_outputs("idle");

        // Auto scan, 3-input XOR
        run_auto(8'h96, 1'b0, 0, "xor");

        // Step mode, majority; mode switch flipped after the start edge
        fn = 8'hE8;
        @(negedge clk_pin);
        ifc.mode_pin  = 1'b1;
        ifc.start_pin = 1'b1;
        repeat (5) @(negedge clk_pin);
        ifc.start_pin = 1'b0;
        ifc.mode_pin  = 1'b0;
        repeat (20) @(negedge clk_pin);
        check("step0_vec", 32'(ifc.dut_in), 32'd0);
        check("step0_table", 32'(ifc.table_out), 32'h00);
        check("step0_busy", 32'(ifc.busy), 32'd1);
        for (int i = 1; i <= 7; i++) begin
            pulse_step();
            check("step_vec", 32'(ifc.dut_in), 32'(i));
            check("step_table", 32'(ifc.table_out), 32'(8'hE8 & 8'((32'd1 << (i + 1)) - 1)));
            check("step_done", 32'(ifc.done), (i == 7) ? 32'd1 : 32'd0);
        end
        pulse_step();
        check("step_extra_table", 32'(ifc.table_out), 32'hE8);
        check("step_extra_done", 32'(ifc.done), 32'd1);
        check("step_extra_vec", 32'(ifc.dut_in), 32'd7);

        // Ignored start/step/mode events during an auto scan
        r = 8'($urandom);
        run_auto(r, 1'b1, 0, "inject");

        // Async reset during vector 4's APPLY, then a fresh scan
        run_auto(8'($urandom), 1'b0, 3 + 4 * PER_VEC, "abort");
        repeat (5) @(negedge clk_pin);
        check_idle_outputs("post_abort");
        run_auto(8'($urandom), 1'b0, 0, "after_abort");

        // Restart from DONE with a constant-1 circuit
        run_auto(8'hFF, 1'b0, 0, "const1");

        // A few more random functions
        for (int n = 0; n < 3; n++) begin
            r = 8'($urandom);
            run_auto(r, n[0], 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
